// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: rotation mode yields (cos, sin) of a binary angle,
// vectoring mode yields (magnitude, atan2) of an (x, y) pair. One micro-rotation
// is performed per clock. Optional macro CORDIC_GAIN_COMP_EN adds a SCALE state
// that removes the CORDIC gain from the vectoring magnitude.
module cordic_iter_engine #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic        [WIDTH-1:0] in_angle,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic        [WIDTH-1:0] out_angle
);

  localparam int DW = WIDTH + 2;

  // atan(2^-i) / (2*pi) * 2^32
  localparam logic [31:0] ATAN32 [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // 0.6072529350 * 2^32
  localparam logic [33:0] K32 = 34'h09B74EDA8;

  localparam int          ATAN_SH  = 32 - WIDTH;
  localparam logic [33:0] ATAN_RND = (WIDTH < 32) ? (34'd1 << ((WIDTH < 32) ? (31 - WIDTH) : 0)) : 34'd0;

  // Rotation start vector pre-scaled by 1/gain, Q1.(WIDTH-2)
  localparam logic signed [DW-1:0] KX0 = DW'((K32 + (34'd1 << (33 - WIDTH))) >> (34 - WIDTH));

  localparam logic [5:0] ITER_C = 6'(ITER);

`ifdef CORDIC_GAIN_COMP_EN
  // Inverse gain as unsigned Q0.WIDTH
  localparam logic [WIDTH-1:0] KS = WIDTH'((K32 + ATAN_RND) >> ATAN_SH);
  localparam logic signed [DW+WIDTH:0] RND_P = {{(DW+1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, SCALE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
`endif

  // Table entry rounded to WIDTH bits, sign-extended into the datapath width
  function automatic logic signed [DW-1:0] atan_w(input logic [5:0] idx);
    logic [33:0] t;
    t = {2'b00, (idx < 6'd32) ? ATAN32[idx[4:0]] : 32'd0};
    return $signed(DW'((t + ATAN_RND) >> ATAN_SH));
  endfunction

  // Clamp a datapath value to the signed WIDTH range
  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [DW-1:0] v);
    if (v[DW-1:WIDTH-1] == '0 || v[DW-1:WIDTH-1] == '1)
      return v[WIDTH-1:0];
    else if (v[DW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  // x * K with round-half-up back to the datapath scale
  function automatic logic signed [DW-1:0] gain_comp(input logic signed [DW-1:0] v);
    logic signed [DW+WIDTH:0] p;
    p = (DW+WIDTH+1)'(v) * (DW+WIDTH+1)'($signed({1'b0, KS}));
    return DW'((p + RND_P) >>> WIDTH);
  endfunction
`endif

  state_t                 state;
  logic             [5:0] cnt;
  logic                   mode_r;
  logic                   neg_r;
  logic                   zero_r;
  logic signed [DW-1:0]   x_r, y_r, z_r;

  logic signed [DW-1:0]   x_init, y_init, z_init;
  logic        [WIDTH-1:0] za;
  logic                   quad;
  logic signed [DW-1:0]   xe, ye;

  logic signed [DW-1:0]   xs, ys, at_i;
  logic                   d_pos;
  logic signed [DW-1:0]   x_nx, y_nx, z_nx;

  logic signed [DW-1:0]   x_fin, y_fin;
  logic signed [WIDTH-1:0] res_x, res_y;
  logic        [WIDTH-1:0] res_a;

  // Start vector from the request operands, including quadrant folding
  always_comb begin
    quad   = in_angle[WIDTH-1] ^ in_angle[WIDTH-2];
    za     = quad ? {~in_angle[WIDTH-1], in_angle[WIDTH-2:0]} : in_angle;
    xe     = {{2{in_x[WIDTH-1]}}, in_x};
    ye     = {{2{in_y[WIDTH-1]}}, in_y};
    x_init = KX0;
    y_init = '0;
    z_init = {{2{za[WIDTH-1]}}, za};
    if (in_mode) begin
      if (in_x[WIDTH-1]) begin
        x_init = -xe;
        y_init = -ye;
        z_init = {2'b00, 1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        x_init = xe;
        y_init = ye;
        z_init = '0;
      end
    end
  end

  // One micro-rotation of the current vector by +/- atan(2^-cnt)
  always_comb begin
    xs    = x_r >>> cnt;
    ys    = y_r >>> cnt;
    at_i  = atan_w(cnt);
    d_pos = mode_r ? y_r[DW-1] : ~z_r[DW-1];
    if (d_pos) begin
      x_nx = x_r - ys;
      y_nx = y_r + xs;
      z_nx = z_r - at_i;
    end else begin
      x_nx = x_r + ys;
      y_nx = y_r - xs;
      z_nx = z_r + at_i;
    end
  end

  // Final result formatting: quadrant un-fold, optional gain removal, saturation
  always_comb begin
    x_fin = neg_r ? -x_r : x_r;
    y_fin = neg_r ? -y_r : y_r;
`ifdef CORDIC_GAIN_COMP_EN
    if (state == SCALE)
      x_fin = gain_comp(x_r);
`endif
    res_x = sat_w(x_fin);
    res_y = sat_w(y_fin);
    res_a = zero_r ? '0 : z_r[WIDTH-1:0];
  end

  // Control FSM with registered handshakes and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_angle <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mode_r   <= in_mode;
            neg_r    <= ~in_mode & quad;
            zero_r   <= in_mode & (in_x == '0) & (in_y == '0);
            x_r      <= x_init;
            y_r      <= y_init;
            z_r      <= z_init;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= COMPUTE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        COMPUTE: begin
          if (cnt == ITER_C) begin
`ifdef CORDIC_GAIN_COMP_EN
            if (mode_r) begin
              state <= SCALE;
            end else begin
              out_x     <= res_x;
              out_y     <= res_y;
              out_angle <= res_a;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`else
            out_x     <= res_x;
            out_y     <= res_y;
            out_angle <= res_a;
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end else begin
            x_r <= x_nx;
            y_r <= y_nx;
            z_r <= z_nx;
            cnt <= cnt + 6'd1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: begin
          out_x     <= res_x;
          out_y     <= res_y;
          out_angle <= res_a;
          out_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: directed corner cases plus
// randomized transactions compared against a floating-point trig model.
module tb_cordic_iter_engine;

  localparam int W = 16;
  localparam int N = 16;
  localparam real PI = 3.14159265358979;
`ifdef CORDIC_GAIN_COMP_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                in_mode = 1'b0;
  logic        [W-1:0] in_angle = '0;
  logic signed [W-1:0] in_x = '0;
  logic signed [W-1:0] in_y = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] out_x;
  logic signed [W-1:0] out_y;
  logic        [W-1:0] out_angle;

  int n_checks = 0;
  int n_errors = 0;

  cordic_iter_engine #(.WIDTH(W), .ITER(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_angle(in_angle), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_angle(out_angle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    n_checks++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic longint rnd(input real r);
    return (r < 0.0) ? longint'($rtoi(r - 0.5)) : longint'($rtoi(r + 0.5));
  endfunction

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Move an expected angle by whole turns so it sits nearest the observed one
  function automatic longint near(input longint obs, input longint exp);
    longint e;
    e = exp;
    if (e - obs > 32768) e -= 65536;
    if (obs - e > 32768) e += 65536;
    return e;
  endfunction

  task automatic run_txn(input bit mode, input logic [W-1:0] ang, input int xi, input int yi,
                         input bit hold, input int stall, input int tol_xy, input int tol_a,
                         input string tag);
    real    th, mag, gain;
    longint ex, ey, ea;
    int     g, lat, busy, exp_lat;
    gain = GC ? 1.0 : 1.6467602;
    if (!mode) begin
      th = real'(ang) * 2.0 * PI / 65536.0;
      ex = sat(rnd($cos(th) * 16384.0));
      ey = sat(rnd($sin(th) * 16384.0));
      ea = 0;
      exp_lat = N + 1;
    end else begin
      mag = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi)) * gain;
      ex  = sat(rnd(mag));
      ey  = 0;
      if (xi == 0 && yi == 0) ea = 0;
      else ea = rnd($atan2(real'(yi), real'(xi)) * 65536.0 / (2.0 * PI));
      if (ea < 0) ea += 65536;
      exp_lat = N + 1 + (GC ? 1 : 0);
    end

    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk({tag, "_rdy"}, longint'(in_ready), 1, 0);
    in_valid = 1'b1;
    in_mode  = mode;
    in_angle = ang;
    in_x     = W'(xi);
    in_y     = W'(yi);
    @(posedge clk); #1;
    if (hold) begin
      in_angle = ang + 16'h4000;
      in_x     = W'(-xi);
      in_y     = W'(-yi);
      in_mode  = ~mode;
    end else begin
      in_valid = 1'b0;
    end

    lat  = 0;
    busy = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) busy++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, lat, exp_lat, 0);
    chk({tag, "_busy"}, busy, 0, 0);
    chk({tag, "_x"}, longint'(out_x), ex, tol_xy);
    chk({tag, "_y"}, longint'(out_y), ey, mode ? 16 : tol_xy);
    chk({tag, "_a"}, longint'(out_angle), near(longint'(out_angle), ea), tol_a);

    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_v"}, longint'(out_valid), 1, 0);
      chk({tag, "_hold_r"}, longint'(in_ready), 0, 0);
      chk({tag, "_hold_x"}, longint'(out_x), ex, tol_xy);
      chk({tag, "_hold_y"}, longint'(out_y), ey, mode ? 16 : tol_xy);
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain"}, longint'(out_valid), 0, 0);
  endtask

  initial begin
    int seen;
    int xi, yi;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", longint'(out_valid), 0, 0);
    chk("rst_ready", longint'(in_ready), 0, 0);
    chk("rst_x", longint'(out_x), 0, 0);
    chk("rst_y", longint'(out_y), 0, 0);
    chk("rst_a", longint'(out_angle), 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_after", longint'(in_ready), 1, 0);

    // Directed rotation points on the axes and the diagonal
    run_txn(1'b0, 16'h0000, 0, 0, 1'b0, 0, 4, 3, "rot0");
    run_txn(1'b0, 16'h2000, 0, 0, 1'b0, 0, 4, 3, "rot45");
    run_txn(1'b0, 16'h4000, 0, 0, 1'b0, 0, 4, 3, "rot90");
    run_txn(1'b0, 16'hC000, 0, 0, 1'b0, 0, 4, 3, "rot270");
    run_txn(1'b0, 16'h8000, 0, 0, 1'b0, 0, 4, 3, "rot180");

    // Directed vectoring, zero vector and output saturation
    run_txn(1'b1, '0, -8192, 8192, 1'b0, 0, GC ? 4 : 6, 4, "vec135");
    run_txn(1'b1, '0, 0, 0, 1'b0, 0, 0, 0, "vec_zero");
    run_txn(1'b1, '0, -32768, 0, 1'b0, 0, 4, 4, "vec_sat");
    run_txn(1'b1, '0, 16384, -16384, 1'b0, 0, 8, 4, "vec_edge");

    // Request held during compute and a 10-cycle output stall
    run_txn(1'b0, 16'h2000, 0, 0, 1'b1, 10, 4, 3, "hold");

    // Reset in the middle of a transaction aborts it
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_angle = 16'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", longint'(out_valid), 0, 0);
    chk("abort_ready", longint'(in_ready), 0, 0);
    @(posedge clk); #1;
    chk("abort_x", longint'(out_x), 0, 0);
    chk("abort_a", longint'(out_angle), 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_after", longint'(in_ready), 1, 0);
    seen = 0;
    repeat (N + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0, 0);

    // Randomized rotation
    for (int k = 0; k < 20; k++)
      run_txn(1'b0, W'($urandom_range(0, 65535)), 0, 0, 1'b0, k % 3, 10, 3, "rrot");

    // Randomized vectoring inside the overflow-free operand range
    for (int k = 0; k < 20; k++) begin
      xi = int'($urandom_range(0, 32768)) - 16384;
      yi = int'($urandom_range(0, 32768)) - 16384;
      if (xi * xi + yi * yi < 1024 * 1024) xi = 5000;
      run_txn(1'b1, '0, xi, yi, 1'b0, k % 2, 12, 6, "rvec");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
